// File: rtl/mux_n_arb_pkg.sv
// Shared definitions for the n-channel select/arbitrate mux:
// mode encodings, output-stage states and a constant clog2 helper.
package mux_n_arb_pkg;

    localparam logic MODE_DIRECTED = 1'b0;
    localparam logic MODE_RR       = 1'b1;

    typedef enum logic {
        StEmpty,
        StFull
    } state_e;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((32'd1 << i) < value) begin
                r = unsigned'(i + 1);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_grant_n.sv
// Round-robin one-hot grant: first requester strictly after ptr, wrapping
// modulo n, found by rotating a doubled request vector and isolating its lowest bit.
module rr_grant_n #(
    parameter int unsigned n  = 3,
    parameter int unsigned sw = 2
) (
    input  logic [n-1:0]  req,
    input  logic [sw-1:0] ptr,
    output logic [n-1:0]  grant
);

    logic [2*n-1:0] w_dbl;
    logic [n-1:0]   w_rot;
    logic [n-1:0]   w_first;
    int unsigned    w_shift;

    always_comb begin
        w_shift = 32'(ptr) + 32'd1;
        w_dbl   = {req, req};
        // Bit k of w_rot is channel (ptr + 1 + k) mod n
        w_rot   = n'(w_dbl >> w_shift);
        w_first = w_rot & (~w_rot + n'(1));
        grant   = n'(({w_first, w_first} << w_shift) >> n);
    end

endmodule

// File: rtl/mux_n_arb.sv
// n-channel valid/ready mux with directed or round-robin selection feeding a
// one-entry registered output stage; sticky flag for out-of-range directed sel.
module mux_n_arb
    import mux_n_arb_pkg::*;
#(
    parameter int unsigned w  = 32,
    parameter int unsigned n  = 3,
    parameter int unsigned sw = (clog2(n) < 1) ? 1 : clog2(n)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [n*w-1:0] in_data,
    input  logic [n-1:0]   in_valid,
    output logic [n-1:0]   in_ready,
    input  logic           mode,
    input  logic [sw-1:0]  sel,
    output logic [w-1:0]   out_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [sw-1:0]  out_src,
    output logic           sel_err
);

    state_e        r_state;
    state_e        w_state_nxt;
    logic [w-1:0]  r_data;
    logic [sw-1:0] r_src;
    logic [sw-1:0] r_ptr;
    logic          r_err;

    logic          w_sel_ok;
    logic          w_load_en;
    logic          w_xfer;
    logic [n-1:0]  w_dir_grant;
    logic [n-1:0]  w_rr_grant;
    logic [n-1:0]  w_grant;
    logic [w-1:0]  w_data_nxt;
    logic [sw-1:0] w_src_nxt;

    rr_grant_n #(
        .n  (n),
        .sw (sw)
    ) u_rr_grant (
        .req   (in_valid),
        .ptr   (r_ptr),
        .grant (w_rr_grant)
    );

    always_comb begin
        w_sel_ok    = 32'(sel) < n;
        w_dir_grant = '0;
        for (int i = 0; i < n; i++) begin
            w_dir_grant[i] = in_valid[i] && (int'(sel) == i);
        end
        w_grant   = (mode == MODE_RR) ? w_rr_grant : w_dir_grant;
        // Reset blocks handshakes so nothing is accepted into a register being cleared
        w_load_en = !rst && ((r_state == StEmpty) || out_ready);
        in_ready  = w_grant & {n{w_load_en}};
        w_xfer    = |in_ready;

        w_data_nxt = '0;
        w_src_nxt  = '0;
        for (int i = 0; i < n; i++) begin
            if (w_grant[i]) begin
                w_data_nxt = in_data[i*w +: w];
                w_src_nxt  = sw'(i);
            end
        end

        w_state_nxt = r_state;
        if (w_load_en) begin
            w_state_nxt = w_xfer ? StFull : StEmpty;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StEmpty;
            r_data  <= '0;
            r_src   <= '0;
            r_ptr   <= sw'(n - 1);
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_xfer) begin
                r_data <= w_data_nxt;
                r_src  <= w_src_nxt;
                if (mode == MODE_RR) begin
                    r_ptr <= w_src_nxt;
                end
            end
            if ((mode == MODE_DIRECTED) && !w_sel_ok && (|in_valid)) begin
                r_err <= 1'b1;
            end
        end
    end

    assign out_valid = (r_state == StFull);
    assign out_data  = r_data;
    assign out_src   = r_src;
    assign sel_err   = r_err;

endmodule

// File: tb/tb_mux_n_arb.sv
// Bench for mux_n_arb: directed scenarios plus randomized traffic checked
// against a cycle-level behavioural model of the mux and output register.
module tb_mux_n_arb;

    localparam int W  = 32;
    localparam int N  = 3;
    localparam int SW = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_ready;
    logic           mode;
    logic [SW-1:0]  sel;
    logic [W-1:0]   out_data;
    logic           out_valid;
    logic           out_ready;
    logic [SW-1:0]  out_src;
    logic           sel_err;

    int checks   = 0;
    int failures = 0;

    // Behavioural model state
    logic          m_valid;
    logic [W-1:0]  m_data;
    logic [SW-1:0] m_src;
    int            m_ptr;
    logic          m_err;

    mux_n_arb #(
        .w  (W),
        .n  (N),
        .sw (SW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .sel       (sel),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_src   (out_src),
        .sel_err   (sel_err)
    );

    always #5 clk = ~clk;

    function automatic int exp_grant();
        if (mode == 1'b0) begin
            if (int'(sel) < N && in_valid[sel]) return int'(sel);
            return -1;
        end
        for (int k = 1; k <= N; k++) begin
            int c;
            c = (m_ptr + k) % N;
            if (in_valid[c]) return c;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] exp_ready();
        int g;
        logic [N-1:0] r;
        g = exp_grant();
        r = '0;
        if (!rst && (!m_valid || out_ready) && g >= 0) r[g] = 1'b1;
        return r;
    endfunction

    // Advance one clock, updating the model from the inputs seen at the edge
    task automatic cycle();
        int   g;
        logic le;
        g  = exp_grant();
        le = !rst && (!m_valid || out_ready);
        if (rst) begin
            m_valid = 1'b0;
            m_data  = '0;
            m_src   = '0;
            m_ptr   = N - 1;
            m_err   = 1'b0;
        end else begin
            if (mode == 1'b0 && int'(sel) >= N && |in_valid) m_err = 1'b1;
            if (le) begin
                if (g >= 0) begin
                    m_valid = 1'b1;
                    m_data  = in_data[g*W +: W];
                    m_src   = SW'(g);
                    if (mode) m_ptr = g;
                end else begin
                    m_valid = 1'b0;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 3'b111; mode = 1'b1; sel = 2'd0; out_ready = 1'b1;
        in_data = {32'hAAAA0002, 32'hAAAA0001, 32'hAAAA0000};
        #1;
        checks++;
        if (in_ready !== 3'b000) begin
            failures++; $display("FAIL reset_ready0 got=%b exp=000", in_ready);
        end
        cycle();
        cycle();
        checks++;
        if (in_ready !== 3'b000) begin
            failures++; $display("FAIL reset_ready got=%b exp=000", in_ready);
        end
        checks++;
        if (out_valid !== 1'b0 || out_data !== 32'h0 || out_src !== 2'd0 || sel_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_state got v=%b d=%h s=%0d e=%b exp v=0 d=0 s=0 e=0",
                     out_valid, out_data, out_src, sel_err);
        end
        rst = 1'b0;
    endtask

    task automatic test_directed();
        mode = 1'b0; sel = 2'd2; in_valid = 3'b111; out_ready = 1'b1;
        in_data = {32'hC0DE0002, 32'hC0DE0001, 32'hC0DE0000};
        #1;
        checks++;
        if (in_ready !== 3'b100) begin
            failures++; $display("FAIL dir_ready got=%b exp=100", in_ready);
        end
        cycle();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'hC0DE0002 || out_src !== 2'd2) begin
            failures++;
            $display("FAIL dir_out got v=%b d=%h s=%0d exp v=1 d=c0de0002 s=2",
                     out_valid, out_data, out_src);
        end
    endtask

    task automatic test_illegal_sel();
        mode = 1'b0; sel = 2'd3; in_valid = 3'b001; out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 3'b000) begin
            failures++; $display("FAIL bad_sel_ready got=%b exp=000", in_ready);
        end
        cycle();
        checks++;
        if (out_valid !== 1'b0 || sel_err !== 1'b1) begin
            failures++; $display("FAIL bad_sel_out got v=%b e=%b exp v=0 e=1", out_valid, sel_err);
        end
        sel = 2'd0;
        #1;
        checks++;
        if (in_ready !== 3'b001) begin
            failures++; $display("FAIL sel0_ready got=%b exp=001", in_ready);
        end
        cycle();
        checks++;
        if (sel_err !== 1'b1 || out_valid !== 1'b1 || out_src !== 2'd0) begin
            failures++;
            $display("FAIL sticky_err got e=%b v=%b s=%0d exp e=1 v=1 s=0", sel_err, out_valid, out_src);
        end
    endtask

    task automatic test_rr_fairness();
        int seq_a[6] = '{0, 1, 2, 0, 1, 2};
        int seq_b[4] = '{0, 2, 0, 2};
        mode = 1'b1; in_valid = 3'b111; out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cycle();
            checks++;
            if (out_src !== SW'(seq_a[i]) || out_valid !== 1'b1) begin
                failures++;
                $display("FAIL rr_all[%0d] got s=%0d v=%b exp s=%0d v=1", i, out_src, out_valid, seq_a[i]);
            end
        end
        in_valid = 3'b101;
        for (int i = 0; i < 4; i++) begin
            cycle();
            checks++;
            if (out_src !== SW'(seq_b[i])) begin
                failures++; $display("FAIL rr_wrap[%0d] got s=%0d exp s=%0d", i, out_src, seq_b[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        mode = 1'b0; sel = 2'd0; in_valid = 3'b001; out_ready = 1'b1;
        in_data = {32'h33333333, 32'h22222222, 32'h11111111};
        cycle();
        out_ready = 1'b0; sel = 2'd1; in_valid = 3'b010;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (in_ready !== 3'b000) begin
                failures++; $display("FAIL bp_ready[%0d] got=%b exp=000", i, in_ready);
            end
            cycle();
            checks++;
            if (out_valid !== 1'b1 || out_data !== 32'h11111111) begin
                failures++;
                $display("FAIL bp_hold[%0d] got v=%b d=%h exp v=1 d=11111111", i, out_valid, out_data);
            end
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 3'b010) begin
            failures++; $display("FAIL bp_release_ready got=%b exp=010", in_ready);
        end
        cycle();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'h22222222 || out_src !== 2'd1) begin
            failures++;
            $display("FAIL bp_release got v=%b d=%h s=%0d exp v=1 d=22222222 s=1",
                     out_valid, out_data, out_src);
        end
    endtask

    task automatic test_reset_midstream();
        mode = 1'b1; in_valid = 3'b010; out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
        cycle();
        rst = 1'b1; in_valid = 3'b111;
        #1;
        checks++;
        if (in_ready !== 3'b000) begin
            failures++; $display("FAIL mid_rst_ready got=%b exp=000", in_ready);
        end
        cycle();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++; $display("FAIL mid_rst_valid got=%b exp=0", out_valid);
        end
        rst = 1'b0; out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 3'b001) begin
            failures++; $display("FAIL post_rst_grant got=%b exp=001", in_ready);
        end
        cycle();
        checks++;
        if (out_src !== 2'd0 || out_valid !== 1'b1) begin
            failures++; $display("FAIL post_rst_src got s=%0d v=%b exp s=0 v=1", out_src, out_valid);
        end
    endtask

    task automatic test_random();
        logic [N-1:0] er;
        for (int i = 0; i < 400; i++) begin
            rst       = ($urandom_range(0, 39) == 0);
            mode      = 1'($urandom_range(0, 1));
            sel       = SW'($urandom_range(0, 3));
            in_valid  = N'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            in_data   = {$urandom, $urandom, $urandom};
            #1;
            er = exp_ready();
            checks++;
            if (in_ready !== er) begin
                failures++; $display("FAIL rand_ready[%0d] got=%b exp=%b", i, in_ready, er);
            end
            cycle();
            checks++;
            if (out_valid !== m_valid || out_data !== m_data || out_src !== m_src || sel_err !== m_err) begin
                failures++;
                $display("FAIL rand_out[%0d] got v=%b d=%h s=%0d e=%b exp v=%b d=%h s=%0d e=%b",
                         i, out_valid, out_data, out_src, sel_err, m_valid, m_data, m_src, m_err);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_data = '0; in_valid = '0; mode = 1'b0; sel = '0; out_ready = 1'b0;
        m_valid = 1'b0; m_data = '0; m_src = '0; m_ptr = N - 1; m_err = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_directed();
        test_illegal_sel();
        test_rr_fairness();
        test_backpressure();
        test_reset_midstream();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mux_n_arb.md
Name: mux_n_arb

Overview:
- Parametrised successor to the team's 3-to-1 tristate select mux: n channels of w bits, each with valid/ready handshake, merged onto one registered output stream.
- Two modes: directed (external sel picks the channel) and round-robin arbitration.
- Out-of-range sel yields no transfer and an error flag, never a floating or undefined output.
- Used in the ALU datapath to merge operand/result sources.

Parameters:
- w, 32, data width per channel.
- n, 3, channel count (2..16).
- sw, 2, select/source width; must satisfy 2**sw >= n.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- in_data  in  n*w  channel i occupies bits [i*w +: w].
- in_valid  in  n  per-channel valid.
- in_ready  out  n  per-channel ready (combinational).
- mode  in  1  0 = directed by sel, 1 = round-robin.
- sel  in  sw  channel index, used when mode=0.
- out_data  out  w  registered data.
- out_valid  out  1  registered valid.
- out_ready  in  1  downstream ready.
- out_src  out  sw  index of the channel that supplied out_data.
- sel_err  out  1  sticky flag: mode=0 with sel>=n while any in_valid is high; cleared only by rst.

Behaviour:
- Reset, sampled on the clk edge while rst=1:
  - out_valid=0, out_data=0, out_src=0, sel_err=0, rr_ptr=n-1.
  - With rr_ptr=n-1, channel 0 has first priority.
- Output stage is a one-entry register with two FSM states:
  - EMPTY (out_valid=0).
  - FULL (out_valid=1).
- load_en = !out_valid || out_ready. This gives full throughput: one transfer per cycle when out_ready is held high.
- Grant, combinational, one-hot or zero:
  - mode=0: grant[sel] = in_valid[sel] if sel<n; else no grant.
  - mode=1: grant goes to the first i with in_valid[i]=1, scanning rr_ptr+1, rr_ptr+2, ... modulo n (wraps from n-1 to 0).
- in_ready[i] = load_en && grant[i]. No ready is asserted for a non-granted channel. in_ready may depend on in_valid.
- Transfer on channel i happens when in_valid[i] && in_ready[i]. On the next edge:
  - out_data <= channel i data; out_src <= i; out_valid <= 1.
  - mode=1 only: rr_ptr <= i. mode=0 transfers leave rr_ptr unchanged.
- When load_en=1 and there is no transfer, out_valid <= 0 on the next edge (EMPTY). out_data and out_src hold their last values.
- FULL && !out_ready: out_data, out_valid and out_src hold stable; all in_ready=0.
- Latency: one cycle from input handshake to out_valid.
- Mode or sel changes take effect on the current cycle's grant only. A word already held in the register is unaffected.
- sel_err sets on any edge where mode=0, sel>=n and |in_valid. It stays set until rst.
- Reset mid-transfer: a held word is dropped, out_valid goes to 0, and no in_ready is issued in the rst cycle (load_en is forced to 0 while rst=1).
- Simultaneous upstream load and downstream drain (FULL, out_ready=1, grant present): the register is replaced in the same edge and out_valid stays 1.

Decomposition:
- Shared package holds:
  - Mode constants MODE_DIRECTED=0 and MODE_RR=1.
  - A clog2 helper function used for the sw default and checks.
- One natural sub-module, rr_grant_n (parameter n): from req[n-1:0] and ptr[sw-1:0], produce a one-hot grant using double-width masking for the wrap.
- The output register and FSM live in mux_n_arb.

Test Plan:
- Reset: hold rst=1 for 2 cycles with all in_valid=1 -> in_ready=0, out_valid=0, out_data=0, sel_err=0.
- Directed, w=32, n=3: mode=0, sel=2, in_valid=3'b111, ch2 data=32'hC0DE0002, out_ready=1 -> in_ready=3'b100; next cycle out_data=32'hC0DE0002, out_src=2.
- Illegal sel: mode=0, sel=3, in_valid=3'b001 -> in_ready=0, out_valid falls to 0, sel_err=1 and stays 1 after sel returns to 0.
- Round-robin fairness: mode=1, in_valid=3'b111 held, out_ready=1 for 6 cycles -> out_src sequence 0,1,2,0,1,2. Then with only in_valid=3'b101 -> grants alternate 0,2,0,2 (wrap from 2 to 0).
- Backpressure: FULL holding 32'h11111111 with out_ready=0 for 4 cycles while ch1 valid -> out_data stable, in_ready=0. Then out_ready=1 -> ch1 accepted the same cycle and out_valid stays 1.
- Reset mid-stream: assert rst while FULL with out_ready=0 -> next edge out_valid=0, rr_ptr=2, and the first post-reset round-robin grant goes to ch0.
